// File: rtl/gray_tag_pkg.sv
// Shared types and helpers for the Gray tag arbiter.
// Holds the FSM state enum, default sizes and binary-to-Gray conversion.
package gray_tag_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;
    localparam int LENW_DEF  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_tag_arbiter_gray_step_counter.sv
// Binary counter with advance enable and a registered Gray-coded output.
// The Gray register is loaded from the next binary value, so both update on the same edge.
module gray_step_counter
    import gray_tag_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_adv,
    output logic [WIDTH-1:0] o_gray
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] w_bin_next;

    assign w_bin_next = r_bin + WIDTH'(1);
    assign o_gray     = r_gray;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else if (i_adv) begin
            r_bin  <= w_bin_next;
            r_gray <= WIDTH'(bin2gray(32'(w_bin_next)));
        end
    end

endmodule

// File: rtl/gray_tag_arbiter.sv
// Round-robin arbiter that hands out bursts of consecutive Gray tags from one
// shared counter; the counter advances only on accepted beats.
//
// state | meaning
// IDLE  | no burst; pick next requester from the round-robin pointer
// ISSUE | streaming beats of the granted burst
module gray_tag_arbiter
    import gray_tag_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int LENW  = LENW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*LENW-1:0] req_len,
    output logic [NREQ-1:0]    grant,
    output logic               tag_valid,
    output logic [WIDTH-1:0]   tag,
    output logic               tag_last,
    input  logic               tag_ready,
    output logic               busy
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            r_state;
    logic [NREQ-1:0]   r_grant;
    logic [LENW-1:0]   r_remaining;
    logic [PTRW-1:0]   r_rr;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;

    logic              w_found;
    logic [PTRW-1:0]   w_sel;
    logic [LENW-1:0]   w_len_raw;
    logic [LENW-1:0]   w_len;
    logic              w_accept;

    // First requester at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req[(int'(r_rr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_sel   = PTRW'((int'(r_rr) + k) % NREQ);
            end
        end
    end

    assign w_len_raw = req_len[int'(w_sel)*LENW +: LENW];
    assign w_len     = (w_len_raw == '0) ? LENW'(1) : w_len_raw;
    assign w_accept  = r_valid & tag_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_remaining <= '0;
            r_rr        <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state     <= ISSUE;
                        r_grant     <= NREQ'(1) << w_sel;
                        r_remaining <= w_len;
                        r_rr        <= PTRW'((int'(w_sel) + 1) % NREQ);
                        r_valid     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_last      <= (w_len == LENW'(1));
                    end
                end
                ISSUE: begin
                    if (w_accept) begin
                        if (r_last) begin
                            r_state     <= IDLE;
                            r_grant     <= '0;
                            r_remaining <= '0;
                            r_valid     <= 1'b0;
                            r_busy      <= 1'b0;
                            r_last      <= 1'b0;
                        end else begin
                            r_remaining <= r_remaining - LENW'(1);
                            r_last      <= (r_remaining == LENW'(2));
                        end
                    end
                end
            endcase
        end
    end

    gray_step_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_adv  (w_accept),
        .o_gray (tag)
    );

    assign grant     = r_grant;
    assign tag_valid = r_valid;
    assign tag_last  = r_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_gray_tag_arbiter.sv
// Directed bench for gray_tag_arbiter: per-cycle vector table plus
// hand-written sequences for counter wrap and reset mid-burst.
module tb_gray_tag_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int LENW  = 4;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ-1:0]      grant;
    logic                 tag_valid;
    logic [WIDTH-1:0]     tag;
    logic                 tag_last;
    logic                 tag_ready;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    int        model_b;
    logic [7:0] prev_tag;
    logic       have_prev;
    logic [7:0] seen [0:15];

    gray_tag_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LENW(LENW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_len   (req_len),
        .grant     (grant),
        .tag_valid (tag_valid),
        .tag       (tag),
        .tag_last  (tag_last),
        .tag_ready (tag_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] len;
        logic        rdy;
        logic [3:0]  g;
        logic        v;
        logic [7:0]  t;
        logic        l;
        logic        b;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] g8(input int b);
        logic [7:0] x;
        x = b[7:0];
        return x ^ (x >> 1);
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One burst from a single requester, all beats accepted; tags checked against model_b.
    task automatic run_burst(input int who, input int len);
        int beats;
        int guard;
        int len_eff;
        len_eff = (len == 0) ? 1 : len;
        req = '0;
        req_len = '0;
        req[who] = 1'b1;
        req_len[who*LENW +: LENW] = LENW'(len);
        tag_ready = 1'b1;
        cyc();
        req = '0;
        chk($sformatf("burst grant r%0d", who), 32'(grant), 32'(1 << who));
        beats = 0;
        guard = 0;
        while (tag_valid && guard < 40) begin
            chk("burst tag", 32'(tag), 32'(g8(model_b)));
            chk("burst last", 32'(tag_last), 32'(beats == len_eff - 1));
            if (have_prev)
                chk("one-bit step", $countones(prev_tag ^ tag), 1);
            if (beats < 16) seen[beats] = tag;
            prev_tag  = tag;
            have_prev = 1'b1;
            model_b++;
            beats++;
            guard++;
            cyc();
        end
        chk("burst beats", beats, len_eff);
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_len   = '0;
        tag_ready = 1'b0;
        have_prev = 1'b0;
        prev_tag  = '0;
        model_b   = 0;

        //          req  len      rdy grant v  tag    last busy
        vecs.push_back('{4'h1, 16'h0003, 1'b1, 4'h1, 1'b1, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h0003, 1'b1, 4'h1, 1'b1, 8'h01, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h0003, 1'b1, 4'h1, 1'b1, 8'h03, 1'b1, 1'b1});
        vecs.push_back('{4'h0, 16'h0003, 1'b1, 4'h0, 1'b0, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{4'h0, 16'h0003, 1'b1, 4'h0, 1'b0, 8'h02, 1'b0, 1'b0});
        vecs.push_back('{4'h6, 16'h0220, 1'b1, 4'h2, 1'b1, 8'h02, 1'b0, 1'b1});
        vecs.push_back('{4'h6, 16'h0220, 1'b1, 4'h2, 1'b1, 8'h06, 1'b1, 1'b1});
        vecs.push_back('{4'h6, 16'h0220, 1'b1, 4'h0, 1'b0, 8'h07, 1'b0, 1'b0});
        vecs.push_back('{4'h6, 16'h0220, 1'b1, 4'h4, 1'b1, 8'h07, 1'b0, 1'b1});
        vecs.push_back('{4'h6, 16'h0220, 1'b1, 4'h4, 1'b1, 8'h05, 1'b1, 1'b1});
        vecs.push_back('{4'h6, 16'h0220, 1'b1, 4'h0, 1'b0, 8'h04, 1'b0, 1'b0});
        vecs.push_back('{4'h6, 16'h0220, 1'b1, 4'h2, 1'b1, 8'h04, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h0220, 1'b1, 4'h2, 1'b1, 8'h0C, 1'b1, 1'b1});
        vecs.push_back('{4'h0, 16'h0220, 1'b1, 4'h0, 1'b0, 8'h0D, 1'b0, 1'b0});
        vecs.push_back('{4'h8, 16'h4000, 1'b0, 4'h8, 1'b1, 8'h0D, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h4000, 1'b1, 4'h8, 1'b1, 8'h0F, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h4000, 1'b0, 4'h8, 1'b1, 8'h0F, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h4000, 1'b0, 4'h8, 1'b1, 8'h0F, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h4000, 1'b1, 4'h8, 1'b1, 8'h0E, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h4000, 1'b0, 4'h8, 1'b1, 8'h0E, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h4000, 1'b1, 4'h8, 1'b1, 8'h0A, 1'b1, 1'b1});
        vecs.push_back('{4'h0, 16'h4000, 1'b0, 4'h8, 1'b1, 8'h0A, 1'b1, 1'b1});
        vecs.push_back('{4'h0, 16'h4000, 1'b1, 4'h0, 1'b0, 8'h0B, 1'b0, 1'b0});
        vecs.push_back('{4'h1, 16'h0000, 1'b1, 4'h1, 1'b1, 8'h0B, 1'b1, 1'b1});
        vecs.push_back('{4'h0, 16'h0000, 1'b1, 4'h0, 1'b0, 8'h09, 1'b0, 1'b0});
        vecs.push_back('{4'h2, 16'h0050, 1'b1, 4'h2, 1'b1, 8'h09, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h0050, 1'b1, 4'h2, 1'b1, 8'h08, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h0050, 1'b1, 4'h2, 1'b1, 8'h18, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h0050, 1'b1, 4'h2, 1'b1, 8'h19, 1'b0, 1'b1});
        vecs.push_back('{4'h0, 16'h0050, 1'b1, 4'h2, 1'b1, 8'h1B, 1'b1, 1'b1});
        vecs.push_back('{4'h0, 16'h0050, 1'b1, 4'h0, 1'b0, 8'h1A, 1'b0, 1'b0});

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset grant", 32'(grant), 0);
        chk("reset valid", 32'(tag_valid), 0);
        chk("reset tag", 32'(tag), 0);
        chk("reset last", 32'(tag_last), 0);
        chk("reset busy", 32'(busy), 0);

        foreach (vecs[i]) begin
            req       = vecs[i].r;
            req_len   = vecs[i].len;
            tag_ready = vecs[i].rdy;
            cyc();
            chk($sformatf("row%0d grant", i), 32'(grant), 32'(vecs[i].g));
            chk($sformatf("row%0d valid", i), 32'(tag_valid), 32'(vecs[i].v));
            chk($sformatf("row%0d tag", i), 32'(tag), 32'(vecs[i].t));
            chk($sformatf("row%0d last", i), 32'(tag_last), 32'(vecs[i].l));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].b));
        end

        // Walk the counter up to binary 254, then cross the wrap.
        model_b   = 19;
        prev_tag  = 8'h1B;
        have_prev = 1'b1;
        while (model_b < 254)
            run_burst(0, (254 - model_b > 15) ? 15 : 254 - model_b);
        chk("pre-wrap idle tag", 32'(tag), 32'h81);
        run_burst(0, 3);
        chk("wrap tag0", 32'(seen[0]), 32'h81);
        chk("wrap tag1", 32'(seen[1]), 32'h80);
        chk("wrap tag2", 32'(seen[2]), 32'h00);
        chk("post-wrap idle tag", 32'(tag), 32'h01);

        // Reset during beat 2 of a 5-beat burst from requester 3.
        req       = 4'h8;
        req_len   = 16'h5000;
        tag_ready = 1'b1;
        cyc();
        req = '0;
        chk("rst-burst grant", 32'(grant), 32'h8);
        chk("rst-burst beat1", 32'(tag), 32'h01);
        cyc();
        chk("rst-burst beat2", 32'(tag), 32'h03);
        #2 reset = 1'b1;
        #1;
        chk("abort grant", 32'(grant), 0);
        chk("abort valid", 32'(tag_valid), 0);
        chk("abort busy", 32'(busy), 0);
        chk("abort last", 32'(tag_last), 0);
        chk("abort tag", 32'(tag), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("release tag", 32'(tag), 0);
        req     = 4'hF;
        req_len = 16'h1111;
        cyc();
        chk("post-rst grant", 32'(grant), 32'h1);
        chk("post-rst tag", 32'(tag), 32'h00);
        chk("post-rst last", 32'(tag_last), 1);
        cyc();
        chk("post-rst bubble", 32'(grant), 0);
        chk("post-rst idle tag", 32'(tag), 32'h01);
        cyc();
        chk("post-rst rr grant", 32'(grant), 32'h2);
        req = '0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
